// File: rtl/fir_band_mixer.sv
// Per-band gain mixer for the FIR bank: one MAC per band per clock, then round-half-up and saturate to 24 bits.
// Optional clip reporting (l_clip, r_clip, clip_count) is built when EQ_CLIP_DETECT_EN is defined.
module fir_band_mixer #(
  parameter int          NUM_OF_FILTERS = 4,
  parameter int          COEF_FRAC      = 15,
  parameter int          GAIN_FRAC      = 14,
  parameter logic [15:0] GAIN_RESET     = 16'h4000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         audio_en,
  input  logic                         data_valid,
  input  logic [NUM_OF_FILTERS*48-1:0] l_data_in,
  input  logic [NUM_OF_FILTERS*48-1:0] r_data_in,
  input  logic                         gain_wr_en,
  input  logic [3:0]                   gain_select,
  input  logic [15:0]                  gain_wr_data,
  input  logic                         overrun_clr,
  output logic [23:0]                  l_data_out,
  output logic [23:0]                  r_data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
`ifdef EQ_CLIP_DETECT_EN
  ,
  output logic                         l_clip,
  output logic                         r_clip,
  output logic [15:0]                  clip_count
`endif
);

  localparam int ACC_W  = 64 + $clog2(NUM_OF_FILTERS);
  localparam int SH     = COEF_FRAC + GAIN_FRAC;
  localparam int BAND_W = $clog2(NUM_OF_FILTERS + 1);
  localparam logic [BAND_W-1:0]       LAST_BAND = BAND_W'(NUM_OF_FILTERS - 1);
  localparam logic signed [ACC_W-1:0] RND       = ACC_W'(1) <<< (SH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(24'sh7FFFFF);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(24'sh800000);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_e;

  state_e                   state_q, state_d;
  logic [BAND_W-1:0]        band_q, band_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [47:0]       l_cap_q [NUM_OF_FILTERS];
  logic signed [47:0]       l_cap_d [NUM_OF_FILTERS];
  logic signed [47:0]       r_cap_q [NUM_OF_FILTERS];
  logic signed [47:0]       r_cap_d [NUM_OF_FILTERS];
  logic signed [15:0]       gain_q  [NUM_OF_FILTERS];
  logic signed [15:0]       gain_d  [NUM_OF_FILTERS];
  logic signed [15:0]       shadow_q[NUM_OF_FILTERS];
  logic signed [15:0]       shadow_d[NUM_OF_FILTERS];
  logic [23:0]              l_out_q, l_out_d, r_out_q, r_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     capture;
  logic signed [47:0]       l_cur, r_cur;
  logic signed [15:0]       g_cur;
  logic signed [63:0]       prod_l, prod_r;
  logic signed [ACC_W-1:0]  l_rnd, r_rnd;
`ifdef EQ_CLIP_DETECT_EN
  logic                     l_clip_q, l_clip_d, r_clip_q, r_clip_d;
  logic [15:0]              clip_count_q, clip_count_d;
  logic                     l_sat, r_sat;
`endif

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    return (a + RND) >>> SH;
  endfunction

  function automatic logic [23:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return 24'h7FFFFF;
    else if (v < SAT_MIN) return 24'h800000;
    else                  return v[23:0];
  endfunction

  // Operand select for the band being accumulated this cycle.
  always_comb begin
    l_cur = '0;
    r_cur = '0;
    g_cur = '0;
    for (int b = 0; b < NUM_OF_FILTERS; b++) begin
      if (band_q == BAND_W'(b)) begin
        l_cur = l_cap_q[b];
        r_cur = r_cap_q[b];
        g_cur = shadow_q[b];
      end
    end
    prod_l = 64'(l_cur) * 64'(g_cur);
    prod_r = 64'(r_cur) * 64'(g_cur);
    l_rnd  = round_shift(acc_l_q);
    r_rnd  = round_shift(acc_r_q);
  end

`ifdef EQ_CLIP_DETECT_EN
  assign l_sat = (l_rnd > SAT_MAX) || (l_rnd < SAT_MIN);
  assign r_sat = (r_rnd > SAT_MAX) || (r_rnd < SAT_MIN);
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves a latch behind.
    state_d     = state_q;
    band_d      = band_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    l_cap_d     = l_cap_q;
    r_cap_d     = r_cap_q;
    gain_d      = gain_q;
    shadow_d    = shadow_q;
    l_out_d     = l_out_q;
    r_out_d     = r_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    capture     = 1'b0;
`ifdef EQ_CLIP_DETECT_EN
    l_clip_d     = l_clip_q;
    r_clip_d     = r_clip_q;
    clip_count_d = clip_count_q;
`endif

    // Out-of-range band indices never match, so those writes fall away.
    for (int b = 0; b < NUM_OF_FILTERS; b++) begin
      if (gain_wr_en && gain_select == 4'(b)) gain_d[b] = gain_wr_data;
    end

    if (overrun_clr) begin
      overrun_d = 1'b0;
`ifdef EQ_CLIP_DETECT_EN
      l_clip_d     = 1'b0;
      r_clip_d     = 1'b0;
      clip_count_d = '0;
`endif
    end

    if (!audio_en) begin
      state_d   = S_IDLE;
      band_d    = '0;
      l_out_d   = '0;
      r_out_d   = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: capture = data_valid;
        S_MAC: begin
          acc_l_d = acc_l_q + ACC_W'(prod_l);
          acc_r_d = acc_r_q + ACC_W'(prod_r);
          band_d  = band_q + BAND_W'(1);
          if (data_valid) overrun_d = 1'b1;  // a new drop wins over a same-cycle clear
          if (band_q == LAST_BAND) state_d = S_ROUND;
        end
        S_ROUND: begin
          l_out_d     = saturate(l_rnd);
          r_out_d     = saturate(r_rnd);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
          capture     = data_valid;
`ifdef EQ_CLIP_DETECT_EN
          if (l_sat) l_clip_d = 1'b1;
          if (r_sat) r_clip_d = 1'b1;
          if ((l_sat || r_sat) && clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'd1;
`endif
        end
        default: state_d = S_IDLE;
      endcase

      // Shadow load reads gain_q, so a write in the capture cycle lands on the next sample.
      if (capture) begin
        for (int b = 0; b < NUM_OF_FILTERS; b++) begin
          l_cap_d[b]  = l_data_in[b*48 +: 48];
          r_cap_d[b]  = r_data_in[b*48 +: 48];
          shadow_d[b] = gain_q[b];
        end
        acc_l_d = '0;
        acc_r_d = '0;
        band_d  = '0;
        state_d = S_MAC;
      end
    end
  end

  // NOTE: flops take non-blocking assignments only; blocking belongs to always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      band_q      <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      l_out_q     <= '0;
      r_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int b = 0; b < NUM_OF_FILTERS; b++) gain_q[b] <= GAIN_RESET;
`ifdef EQ_CLIP_DETECT_EN
      l_clip_q     <= 1'b0;
      r_clip_q     <= 1'b0;
      clip_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      l_out_q     <= l_out_d;
      r_out_q     <= r_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      gain_q      <= gain_d;
`ifdef EQ_CLIP_DETECT_EN
      l_clip_q     <= l_clip_d;
      r_clip_q     <= r_clip_d;
      clip_count_q <= clip_count_d;
`endif
    end
  end

  // NOTE: sample and shadow registers carry no reset; they are always written at capture before MAC reads them.
  always_ff @(posedge clk) begin
    l_cap_q  <= l_cap_d;
    r_cap_q  <= r_cap_d;
    shadow_q <= shadow_d;
  end

  assign l_data_out = l_out_q;
  assign r_data_out = r_out_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
`ifdef EQ_CLIP_DETECT_EN
  assign l_clip     = l_clip_q;
  assign r_clip     = r_clip_q;
  assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_fir_band_mixer.sv
// Bench for fir_band_mixer: directed vector table, multi-cycle corner sequences, and random samples
// checked against an arithmetic model of the gain/sum/round/saturate rule.
module tb_fir_band_mixer;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset, audio_en, data_valid, gain_wr_en, overrun_clr;
  logic [3:0]        gain_select;
  logic [15:0]       gain_wr_data;
  logic [N*48-1:0]   l_data_in, r_data_in;
  logic [23:0]       l_data_out, r_data_out;
  logic              out_valid, busy, overrun;
`ifdef EQ_CLIP_DETECT_EN
  logic              l_clip, r_clip;
  logic [15:0]       clip_count;
`endif

  fir_band_mixer #(.NUM_OF_FILTERS(N)) dut (
    .clk(clk), .reset(reset), .audio_en(audio_en), .data_valid(data_valid),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .gain_wr_en(gain_wr_en), .gain_select(gain_select), .gain_wr_data(gain_wr_data),
    .overrun_clr(overrun_clr),
    .l_data_out(l_data_out), .r_data_out(r_data_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
`ifdef EQ_CLIP_DETECT_EN
    , .l_clip(l_clip), .r_clip(r_clip), .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [N-1:0][15:0] mgain;

  typedef struct {
    logic [N*48-1:0]    l;
    logic [N*48-1:0]    r;
    logic [N-1:0][15:0] g;
    logic [23:0]        exp_l;
    logic [23:0]        exp_r;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input int sel, input logic [15:0] g);
    gain_select  = 4'(sel);
    gain_wr_data = g;
    gain_wr_en   = 1'b1;
    tick();
    gain_wr_en   = 1'b0;
    if (sel < N) mgain[sel] = g;
  endtask

  // Waits (bounded) for out_valid; lat is the tick count, 0 if it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      data_valid = 1'b0;
      gain_wr_en = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_sample(input logic [N*48-1:0] l, input logic [N*48-1:0] r,
                            output int lat, output logic [23:0] ol, output logic [23:0] orr);
    l_data_in  = l;
    r_data_in  = r;
    data_valid = 1'b1;
    wait_valid(lat);
    ol  = l_data_out;
    orr = r_data_out;
  endtask

  // Reference: exact sum of products, then floor((sum + 2^28) / 2^29), clamped to 24 bits.
  function automatic logic [23:0] mix1(input logic [N*48-1:0] d, input logic [N-1:0][15:0] g);
    logic signed [127:0] sum, q;
    sum = '0;
    for (int b = 0; b < N; b++) sum += 128'($signed(d[b*48 +: 48])) * 128'($signed(g[b]));
    q = (sum + 128'sd268435456) >>> 29;
    if (q > 128'sd8388607)  return 24'h7FFFFF;
    if (q < -128'sd8388608) return 24'h800000;
    return q[23:0];
  endfunction

  task automatic rand_bands(output logic [N*48-1:0] d);
    logic [63:0]        t;
    logic signed [47:0] s;
    for (int b = 0; b < N; b++) begin
      t = {$urandom, $urandom};
      s = t[47:0];
      d[b*48 +: 48] = s >>> $urandom_range(8, 30);
    end
  endtask

  initial begin
    int lat, pulses;
    logic [23:0] ol, orr;
    logic [N*48-1:0] rl, rr;
    logic [47:0] expq[$];
    logic [47:0] e;

    for (int i = 0; i < 6; i++) begin
      vecs[i].l = '0;
      vecs[i].r = '0;
      vecs[i].g = {N{16'h4000}};
    end
    vecs[0].l[47:0]   = 48'h0000_0000_8000;                     // 1.0 in band0
    vecs[0].exp_l     = 24'd1;        vecs[0].exp_r = 24'd0;
    vecs[1].g         = {16'h4000, 16'h4000, 16'hC000, 16'h4000};
    vecs[1].l[95:48]  = 48'h0000_0032_0000;                     // 100.0 in band1, gain -1
    vecs[1].r[47:0]   = 48'h0000_0003_8000;                     // 7.0 in band0
    vecs[1].exp_l     = 24'hFFFF9C;   vecs[1].exp_r = 24'd7;
    vecs[2].g         = {N{16'h7FFF}};
    vecs[2].l         = {N{48'h7FFF_FFFF_FFFF}};
    vecs[2].r         = {N{48'h8000_0000_0000}};
    vecs[2].exp_l     = 24'h7FFFFF;   vecs[2].exp_r = 24'h800000;
    vecs[3].l[47:0]   = 48'h0000_0000_4000;                     // +0.5 rounds up
    vecs[3].r[47:0]   = 48'hFFFF_FFFF_C000;                     // -0.5 rounds up to 0
    vecs[3].exp_l     = 24'd1;        vecs[3].exp_r = 24'd0;
    vecs[4].l[191:144] = 48'h003F_FFFF_8000;                    // exactly 2^23-1, no clip
    vecs[4].r[47:0]   = 48'hFFFF_FFFF_4000;                     // -1.5 -> -1
    vecs[4].exp_l     = 24'h7FFFFF;   vecs[4].exp_r = 24'hFFFFFF;
    vecs[5].l[47:0]   = 48'h003F_FFFF_C000;                     // 2^23-0.5 rounds past max
    vecs[5].r[143:96] = 48'hFFC0_0000_0000;                     // exactly -2^23, no clip
    vecs[5].exp_l     = 24'h7FFFFF;   vecs[5].exp_r = 24'h800000;

    reset = 1'b1; audio_en = 1'b1; data_valid = 1'b0; gain_wr_en = 1'b0; overrun_clr = 1'b0;
    gain_select = '0; gain_wr_data = '0; l_data_in = '0; r_data_in = '0;
    mgain = {N{16'h4000}};
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_l_out", 64'(l_data_out), 64'd0);
    check("reset_r_out", 64'(r_data_out), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < N; b++) write_gain(b, vecs[i].g[b]);
      run_sample(vecs[i].l, vecs[i].r, lat, ol, orr);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
      check($sformatf("vec%0d_l", i), 64'(ol), 64'(vecs[i].exp_l));
      check($sformatf("vec%0d_r", i), 64'(orr), 64'(vecs[i].exp_r));
      tick();
      check($sformatf("vec%0d_pulse_width", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d_hold", i), 64'(l_data_out), 64'(vecs[i].exp_l));
    end
`ifdef EQ_CLIP_DETECT_EN
    check("clip_count_after_vectors", 64'(clip_count), 64'd2);
    check("l_clip_sticky", 64'(l_clip), 64'd1);
    check("r_clip_sticky", 64'(r_clip), 64'd1);
`endif

    // Second strobe two clocks after the first lands in MAC and is dropped.
    l_data_in = '0; l_data_in[47:0] = 48'h8000; r_data_in = '0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    check("busy_in_mac", 64'(busy), 64'd1);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("overrun_single_output", 64'(pulses), 64'd1);
    check("overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'd0);
`ifdef EQ_CLIP_DETECT_EN
    check("clip_count_cleared", 64'(clip_count), 64'd0);
    check("l_clip_cleared", 64'(l_clip), 64'd0);
`endif

    // Back-to-back strobes every N+1 clocks with random data and gains.
    for (int b = 0; b < N; b++) write_gain(b, 16'($urandom));
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      if (k % (N + 1) == 0 && k < 4 * (N + 1)) begin
        rand_bands(rl);
        rand_bands(rr);
        l_data_in = rl;
        r_data_in = rr;
        data_valid = 1'b1;
        expq.push_back({mix1(rl, mgain), mix1(rr, mgain)});
      end else begin
        data_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        pulses++;
        if (expq.size() == 0) begin
          check("b2b_unexpected_output", 64'(pulses), 64'd0);
        end else begin
          e = expq.pop_front();
          check("b2b_l", 64'(l_data_out), 64'(e[47:24]));
          check("b2b_r", 64'(r_data_out), 64'(e[23:0]));
        end
      end
    end
    data_valid = 1'b0;
    check("b2b_output_count", 64'(pulses), 64'd4);
    check("b2b_no_overrun", 64'(overrun), 64'd0);

    // Gain timing: write during MAC hits the next sample; write on the capture cycle does not.
    for (int b = 0; b < N; b++) write_gain(b, 16'h4000);
    l_data_in = '0; l_data_in[47:0] = 48'h1_8000; l_data_in[95:48] = 48'h2_8000;  // band0=3, band1=5
    r_data_in = '0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    gain_select = 4'd1; gain_wr_data = 16'hC000; gain_wr_en = 1'b1; mgain[1] = 16'hC000;
    wait_valid(lat);
    check("midmac_write_old_gain", 64'(l_data_out), 64'd8);
    run_sample(l_data_in, r_data_in, lat, ol, orr);
    check("midmac_write_next_sample", 64'(ol), 64'hFFFFFE);
    gain_select = 4'd1; gain_wr_data = 16'h4000; gain_wr_en = 1'b1; mgain[1] = 16'h4000;
    run_sample(l_data_in, r_data_in, lat, ol, orr);
    check("capture_cycle_write_unseen", 64'(ol), 64'hFFFFFE);
    run_sample(l_data_in, r_data_in, lat, ol, orr);
    check("capture_cycle_write_later", 64'(ol), 64'd8);
    write_gain(4, 16'h0000);
    write_gain(15, 16'h0000);
    run_sample(l_data_in, r_data_in, lat, ol, orr);
    check("out_of_range_select_ignored", 64'(ol), 64'd8);

    // audio_en low mid-MAC aborts, zeroes outputs and clears overrun; gains survive.
    l_data_in = '0; l_data_in[47:0] = 48'h4_8000;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("abort_pre_overrun", 64'(overrun), 64'd1);
    audio_en = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_l_out", 64'(l_data_out), 64'd0);
    check("abort_overrun", 64'(overrun), 64'd0);
    audio_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort_no_output", 64'(pulses), 64'd0);
    l_data_in = '0; l_data_in[95:48] = 48'h2_8000;
    run_sample(l_data_in, '0, lat, ol, orr);
    check("abort_gains_kept", 64'(ol), 64'd5);

    // Random samples with random gain writes, including out-of-range selects.
    for (int i = 0; i < 16; i++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--) write_gain($urandom_range(0, 7), 16'($urandom));
      rand_bands(rl);
      rand_bands(rr);
      run_sample(rl, rr, lat, ol, orr);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd6);
      check($sformatf("rand%0d_l", i), 64'(ol), 64'(mix1(rl, mgain)));
      check($sformatf("rand%0d_r", i), 64'(orr), 64'(mix1(rr, mgain)));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
